rptr_fwft_reader: RTL and testbench

//  Read-side consumer of the async FIFO, in the i_rclk domain. Drives the pop request into the

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fwft_buf2.sv | 46 ++++
 rtl/rptr_fwft_reader.sv | 73 +++++++
 tb/tb_rptr_fwft_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and parameter checks for the async FIFO read side
//   OUT_DEPTH  : capacity of the FWFT output buffer
//   OCC_W      : width of the occupancy count (0..OUT_DEPTH)
//   rd_lat_ok  : true when a memory read latency is supported (0 or 1 cycles)
package fifo_pkg;
  localparam int OUT_DEPTH = 2;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  function automatic bit rd_lat_ok(input int lat);
    return lat == 0 || lat == 1;
  endfunction
endpackage

// File: rtl/fwft_buf2.sv
// fwft_buf2: in-order 2-entry head/tail queue feeding the FWFT output
//   i_rclk, i_rrst_n : read clock, async active-low reset
//   i_push, i_din    : word arriving from memory
//   i_pop            : head word taken downstream (only while o_occ != 0)
//   o_head           : registered head word
//   o_occ            : words held, 0..2
module fwft_buf2
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                i_rclk,
  input  logic                i_rrst_n,
  input  logic                i_push,
  input  logic [DATASIZE-1:0] i_din,
  input  logic                i_pop,
  output logic [DATASIZE-1:0] o_head,
  output logic [OCC_W-1:0]    o_occ
);
  logic [DATASIZE-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [OCC_W-1:0]    r_occ, w_occ_nxt;

  // Head refills from tail when a full buffer drains; an arriving word lands
  // in head only when head is free after this edge, otherwise in tail.
  always_comb begin
    w_occ_nxt  = r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
    w_head_nxt = (i_pop && r_occ == OCC_W'(OUT_DEPTH)) ? r_tail :
                 (i_push && (r_occ == '0 || i_pop)) ? i_din : r_head;
    w_tail_nxt = (i_push && (i_pop ? r_occ == OCC_W'(OUT_DEPTH) : r_occ == OCC_W'(1))) ? i_din : r_tail;
  end

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_occ  <= w_occ_nxt;
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;
endmodule

// File: rtl/rptr_fwft_reader.sv
// rptr_fwft_reader: async FIFO read-side consumer presenting a FWFT valid/ready stream
//   i_rclk, i_rrst_n : read clock, async active-low reset (shared with pointer block)
//   i_rempty_flag    : registered empty flag from the read-pointer block
//   o_r_en           : combinational pop request to the read-pointer block
//   i_rdata          : memory data at the current read address (RD_LAT cycles after pop)
//   o_valid, i_ready : downstream handshake
//   o_data           : registered head word
//   o_occupancy      : words held in the output buffer
module rptr_fwft_reader
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                i_rclk,
  input  logic                i_rrst_n,
  input  logic                i_rempty_flag,
  output logic                o_r_en,
  input  logic [DATASIZE-1:0] i_rdata,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATASIZE-1:0] o_data,
  output logic [1:0]          o_occupancy
);
  localparam bit LAT_OK = rd_lat_ok(RD_LAT);

  logic [OCC_W-1:0] w_occ;
  logic [OCC_W:0]   w_committed;
  logic             w_fire, w_arrive, w_inflight;

  if (!LAT_OK) begin : g_bad_lat
    $error("RD_LAT must be 0 or 1");
  end

  if (RD_LAT == 1) begin : g_lat1
    logic r_inflight;
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
      if (!i_rrst_n) r_inflight <= 1'b0;
      else           r_inflight <= o_r_en;
    end
    assign w_inflight = r_inflight;
    assign w_arrive   = r_inflight;
  end else begin : g_lat0
    assign w_inflight = 1'b0;
    assign w_arrive   = o_r_en;
  end

  assign o_valid     = w_occ != '0;
  assign o_occupancy = 2'(w_occ);
  assign w_fire      = o_valid && i_ready;
  assign w_committed = {1'b0, w_occ} + (OCC_W+1)'(w_inflight);
  // Credit: a slot being vacated this edge may be refilled by this pop.
  // o_r_en already excludes empty, so it doubles as the accepted-pop strobe.
  assign o_r_en = i_rrst_n && !i_rempty_flag &&
                  (w_committed < (OCC_W+1)'(OUT_DEPTH) + (OCC_W+1)'(w_fire));

  fwft_buf2 #(.DATASIZE(DATASIZE)) u_buf (
    .i_rclk  (i_rclk),
    .i_rrst_n(i_rrst_n),
    .i_push  (w_arrive),
    .i_din   (i_rdata),
    .i_pop   (w_fire),
    .o_head  (o_data),
    .o_occ   (w_occ)
  );

  always_ff @(posedge i_rclk) begin
    if (i_rrst_n) begin
      assert (w_committed <= (OCC_W+1)'(OUT_DEPTH));
      assert (!(o_r_en && i_rempty_flag));
    end
  end
endmodule

// File: tb/tb_rptr_fwft_reader.sv
// tb_rptr_fwft_reader: scoreboard bench for both RD_LAT variants of rptr_fwft_reader
module tb_rptr_fwft_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cur = 1'b1;
  logic       rdy_v = 1'b0, emp_v = 1'b1;
  logic [7:0] rd_v = '0;
  wire        r_en0, r_en1, valid0, valid1;
  wire  [7:0] data0, data1;
  wire  [1:0] occ0, occ1;

  rptr_fwft_reader #(.DATASIZE(8), .RD_LAT(0)) u0 (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_rempty_flag(cur ? 1'b1 : emp_v), .o_r_en(r_en0),
    .i_rdata(rd_v), .o_valid(valid0), .i_ready(cur ? 1'b0 : rdy_v), .o_data(data0), .o_occupancy(occ0));
  rptr_fwft_reader #(.DATASIZE(8), .RD_LAT(1)) u1 (
    .i_rclk(clk), .i_rrst_n(rst_n), .i_rempty_flag(cur ? emp_v : 1'b1), .o_r_en(r_en1),
    .i_rdata(rd_v), .o_valid(valid1), .i_ready(cur ? rdy_v : 1'b0), .o_data(data1), .o_occupancy(occ1));

  wire       r_en_c  = cur ? r_en1 : r_en0;
  wire       valid_c = cur ? valid1 : valid0;
  wire [7:0] data_c  = cur ? data1 : data0;
  wire [1:0] occ_c   = cur ? occ1 : occ0;

  logic [7:0] mem [2048];
  logic [7:0] exp_q [$];
  logic [7:0] lat_q = '0;
  int rp = 0, wp = 0, m_occ = 0, n_cmp = 0, n_err = 0;
  bit prev_pop = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s (RD_LAT=%0d) at %0t: got %0d, expected %0d", name, cur, $time, act, req);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wp] = w;
    wp++;
    exp_q.push_back(w);
  endtask

  // One cycle, entered and left at a falling edge; inputs applied here, outputs
  // sampled just before the rising edge, model advanced just after it.
  task automatic step(input bit rdy, output bit pop, output bit vld, output bit fire);
    bit arrive;
    rdy_v = rdy;
    emp_v = (rp == wp);
    rd_v  = cur ? lat_q : mem[rp];
    #4;
    vld  = valid_c;
    pop  = r_en_c && !emp_v;
    fire = vld && rdy;
    chk("pop_while_empty", int'(r_en_c && emp_v), 0);
    @(posedge clk);
    #1;
    if (pop) begin
      lat_q = mem[rp];
      rp++;
    end
    arrive   = cur ? prev_pop : pop;
    prev_pop = pop;
    m_occ    = m_occ + int'(arrive) - int'(fire);
    chk("occupancy", int'(occ_c), m_occ);
    chk("valid_vs_occ", int'(valid_c), int'(m_occ != 0));
    @(negedge clk);
  endtask

  task automatic do_reset(input logic which);
    #2;
    rst_n = 1'b0;
    cur   = which;
    emp_v = 1'b0;
    rdy_v = 1'b1;
    #1;
    chk("rst_valid", int'(valid_c), 0);
    chk("rst_occupancy", int'(occ_c), 0);
    chk("rst_r_en", int'(r_en_c), 0);
    rp = wp;
    exp_q.delete();
    m_occ = 0;
    prev_pop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    emp_v = 1'b1;
    rdy_v = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && valid_c && rdy_v) begin
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else                   chk("data_order", int'(data_c), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic burst();
    bit p, v, f;
    int fp = -1, lp = -1, fv = -1, ff = -1, lf = -1, np = 0, nf = 0;
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    for (int s = 0; s < 14; s++) begin
      step(1'b1, p, v, f);
      if (p) begin np++; lp = s; if (fp < 0) fp = s; end
      if (f) begin nf++; lf = s; if (ff < 0) ff = s; end
      if (v && fv < 0) fv = s;
    end
    chk("burst_pops", np, 8);
    chk("burst_pop_span", lp - fp, 7);
    chk("burst_first_valid_lat", fv - fp, cur ? 2 : 1);
    chk("burst_fires", nf, 8);
    chk("burst_fire_span", lf - ff, 7);
  endtask

  task automatic backpressure();
    bit p, v, f;
    int np = 0, nf = 0, ff = -1, lf = -1;
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    for (int s = 0; s < 6; s++) begin
      step(1'b0, p, v, f);
      np += int'(p);
      if (v) chk("bp_head_stable", int'(data_c), 8'hA1);
    end
    chk("bp_pops", np, 2);
    chk("bp_occ", int'(occ_c), 2);
    for (int s = 0; s < 6; s++) begin
      step(1'b1, p, v, f);
      if (f) begin nf++; lf = s; if (ff < 0) ff = s; end
    end
    chk("bp_fires", nf, 3);
    chk("bp_fire_span", lf - ff, 2);
  endtask

  task automatic empty_boundary();
    bit p, v, f;
    int np = 0, nf = 0;
    push_word(8'h5C);
    for (int s = 0; s < 6; s++) begin
      step(1'b1, p, v, f);
      np += int'(p);
      nf += int'(f);
    end
    chk("eb_pops", np, 1);
    chk("eb_fires", nf, 1);
    chk("eb_valid_end", int'(valid_c), 0);
  endtask

  task automatic simultaneous();
    bit p, v, f;
    push_word(8'h31);
    for (int s = 0; s < 3; s++) step(1'b0, p, v, f);
    push_word(8'h32);
    step(1'b0, p, v, f);
    chk("sim_pop", int'(p), 1);
    step(1'b1, p, v, f);
    chk("sim_occ_hold", int'(occ_c), 1);
    chk("sim_head_adv", int'(data_c), 8'h32);
    for (int s = 0; s < 3; s++) step(1'b1, p, v, f);
  endtask

  task automatic reset_midstream();
    bit p, v, f;
    int nf = 0;
    push_word(8'h61); push_word(8'h62); push_word(8'h63);
    for (int s = 0; s < 4; s++) step(1'b0, p, v, f);
    chk("rm_occ_full", int'(occ_c), 2);
    do_reset(cur);
    push_word(8'h71); push_word(8'h72); push_word(8'h73);
    for (int s = 0; s < 4; s++) step(1'b0, p, v, f);
    step(1'b1, p, v, f);
    chk("rm_inflight_pop", int'(p), 1);
    do_reset(cur);
    push_word(8'h77);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, p, v, f);
      nf += int'(f);
    end
    chk("rm_after_fires", nf, 1);
  endtask

  task automatic random_run();
    bit p, v, f;
    int guard = 0;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 1) == 1) push_word(8'($urandom));
      step($urandom_range(0, 3) != 0, p, v, f);
    end
    while (exp_q.size() != 0 && guard < 60) begin
      step(1'b1, p, v, f);
      guard++;
    end
    chk("rand_drained", exp_q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b1);
    burst();
    backpressure();
    empty_boundary();
    simultaneous();
    reset_midstream();
    random_run();
    do_reset(1'b0);
    burst();
    backpressure();
    empty_boundary();
    random_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
